// File: rtl/sim_ctrl_pkg.sv
// sim_ctrl_pkg: shared FSM state encoding and default simulation-control constants.
package sim_ctrl_pkg;
  typedef enum logic [2:0] {HOLD, RUN, DUMP_RD, DUMP_TX, DONE} state_t;
  localparam int DEF_RST_CYCLES = 2;
  localparam int DEF_MAX_CYCLES = 200;
  localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_0FFC;
endpackage

// File: rtl/reg_dump_seq.sv
// reg_dump_seq: walks the register file once, one valid/ready beat per register.
module reg_dump_seq
  import sim_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int RA_W  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [RA_W-1:0] rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [RA_W-1:0] dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            fin
);
  state_t ds, ds_nx;
  logic [RA_W-1:0] idx;
  logic last;
  assign last = idx == RA_W'(NREGS - 1);
  assign rf_raddr = idx;
  assign fin = ds == DUMP_TX && dump_ready && last;
  // HOLD doubles as the idle state of this sequencer
  always_comb begin
    ds_nx = start ? DUMP_RD
          : ds == DUMP_RD ? DUMP_TX
          : (ds == DUMP_TX && dump_ready) ? (last ? HOLD : DUMP_RD)
          : ds;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ds         <= HOLD;
      idx        <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
    end else begin
      ds <= ds_nx;
      if (start) idx <= '0;
      if (ds == DUMP_RD) begin
        dump_data  <= rf_rdata;
        dump_idx   <= idx;
        dump_valid <= 1'b1;
      end
      if (ds == DUMP_TX && dump_ready) begin
        dump_valid <= 1'b0;
        if (!last) idx <= idx + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sim_controller.sv
// sim_controller: holds the core in reset, watches for the tohost store or a
// timeout, then halts the core and dumps its register file.
module sim_controller
  import sim_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(DEF_TOHOST_ADDR),
  localparam int RA_W = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            core_rst,
  output logic            core_halt,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  output logic [RA_W-1:0] rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [RA_W-1:0] dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [XLEN-1:0] exit_code,
  output logic [31:0]     cycle_count
);
  state_t state, state_nx;
  logic [31:0] hold_cnt;
  logic store, expire, fin;
  assign store  = state == RUN && mem_we && mem_addr == TOHOST_ADDR;
  assign expire = state == RUN && MAX_CYCLES != 0 && cycle_count == 32'(MAX_CYCLES - 1) && !store;
  assign core_rst  = state == HOLD;
  assign core_halt = state == DUMP_RD || state == DONE;
  assign done      = state == DONE;
  // DUMP_RD here spans the whole dump; the sequencer owns the RD/TX split
  always_comb begin
    state_nx = state == HOLD ? (hold_cnt == 32'(RST_CYCLES - 1) ? RUN : HOLD)
             : state == RUN ? ((store || expire) ? DUMP_RD : RUN)
             : state == DUMP_RD ? (fin ? DONE : DUMP_RD)
             : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      exit_code   <= '0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      state <= state_nx;
      if (state == HOLD) hold_cnt <= hold_cnt + 32'd1;
      if (state == RUN && !store && !expire) cycle_count <= cycle_count + 32'd1;
      if (store) begin
        exit_code <= mem_wdata;
        pass      <= mem_wdata == XLEN'(1);
      end
      if (expire) begin
        timeout <= 1'b1;
        pass    <= 1'b0;
      end
    end
  end
  reg_dump_seq #(.XLEN(XLEN), .NREGS(NREGS), .RA_W(RA_W)) u_dump (
    .clk        (clk),
    .rst        (rst),
    .start      (store || expire),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .fin        (fin)
  );
endmodule
